stall_sched: RTL and testbench
==============================

STALL_SCHED -- requirements
Module: stall_sched

Interface
REQ-001 Parameter MDU_TIMEOUT, default 64: maximum cycles in BUSY before the multi-cycle unit is abandoned.
REQ-002 Parameter `StallBus` width, fixed at 6 by lib/defines.vh; bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 stallreq_for_load  input  1  load-use hazard detected in ID.
REQ-006 mdu_start  input  1  EX issues a multi-cycle mul/div op (one-cycle pulse).
REQ-007 mdu_ready  input  1  mul/div result valid (one-cycle pulse).
REQ-008 excp_req  input  1  exception or redirect raised in MEM.
REQ-009 excp_pc  input  32  redirect target, sampled with excp_req.
REQ-010 stall  output  6  per-stage stall vector, combinational from state and inputs.
REQ-011 flush  output  1  pipeline flush pulse, registered.
REQ-012 new_pc  output  32  redirect target, registered, valid while flush=1.
REQ-013 mdu_cancel  output  1  abort pulse to mul/div unit, registered.
REQ-014 mdu_timeout_err  output  1  sticky timeout flag, registered.

Function
REQ-015 States SHALL be IDLE, BUSY, FLUSH; reset state IDLE.
REQ-016 Priority each cycle SHALL be excp_req > mdu activity > stallreq_for_load.
REQ-017 Any state except FLUSH with excp_req=1: next state FLUSH, flush=1 and new_pc=excp_pc next cycle, stall=0 this cycle.
REQ-018 excp_req while in BUSY SHALL also pulse mdu_cancel for the same cycle flush is 1.
REQ-019 FLUSH lasts exactly one cycle; stall=0; excp_req, mdu_start, stallreq_for_load ignored; next state IDLE.
REQ-020 IDLE, mdu_start=1, no excp_req: stall=6'b001111 same cycle, next state BUSY, timeout counter cleared to 0.
REQ-021 IDLE, only stallreq_for_load=1: stall=6'b000111 same cycle, state stays IDLE.
REQ-022 BUSY, mdu_ready=0: stall=6'b001111, counter increments; stallreq_for_load and mdu_start ignored.
REQ-023 BUSY, mdu_ready=1: stall=0 that cycle, next state IDLE.
REQ-024 BUSY, counter = MDU_TIMEOUT-1 and mdu_ready=0: stall=0 that cycle, next cycle mdu_cancel=1 and mdu_timeout_err=1, state IDLE.
REQ-025 mdu_ready in IDLE or FLUSH SHALL be ignored.
REQ-026 Counter width SHALL be clog2(MDU_TIMEOUT)+1 bits; no wrap within BUSY.
REQ-027 mdu_timeout_err SHALL stay set until reset.

Reset
REQ-028 With rst=0 at a rising edge: state IDLE, counter 0, flush 0, new_pc 32'h0, mdu_cancel 0, mdu_timeout_err 0.
REQ-029 While rst=0, stall SHALL be 6'b0 regardless of inputs.
REQ-030 Reset asserted mid-BUSY or mid-FLUSH SHALL abandon the operation with no mdu_cancel pulse.

Configuration
REQ-031 Macro STALL_SCHED_PERF_EN defined: add outputs stall_cnt[31:0] and flush_cnt[15:0].
REQ-032 stall_cnt counts cycles with stall!=0; flush_cnt counts flush pulses; both saturate at all-ones and reset to 0.
REQ-033 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-034 IDLE, stallreq_for_load=1 for 1 cycle -> stall=6'b000111 that cycle only; flush=0.
REQ-035 mdu_start at cycle 0, mdu_ready at cycle 5 -> stall=6'b001111 cycles 0-4, 6'b0 at cycle 5, IDLE at cycle 6.
REQ-036 excp_req=1, excp_pc=32'hBFC00380 at cycle 3 of BUSY -> next cycle flush=1, new_pc=32'hBFC00380, mdu_cancel=1; one cycle later IDLE, flush=0.
REQ-037 mdu_start and excp_req same cycle -> stall=0, FLUSH next cycle, BUSY never entered, mdu_cancel=0.
REQ-038 MDU_TIMEOUT=8, mdu_start with no mdu_ready -> stall=6'b001111 for 8 cycles, then mdu_cancel pulse and mdu_timeout_err=1 until rst=0.
REQ-039 PERF_EN built: scenario REQ-035 followed by REQ-036 -> stall_cnt=8, flush_cnt=1.

Source files
------------

// File: rtl/stall_sched.sv
// Pipeline stall/flush scheduler: load-use stalls, multi-cycle mul/div stalls with timeout, exception flush.
// Optional macro STALL_SCHED_PERF_EN adds saturating stall_cnt / flush_cnt performance counters.
//
// state | meaning
// IDLE  | no multi-cycle op outstanding; load-use stalls and new mdu ops accepted
// BUSY  | mul/div in flight; front of pipe held until ready, timeout or exception
// FLUSH | one-cycle redirect; all requests ignored
module stall_sched #(
    parameter int MDU_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_for_load,
    input  logic        mdu_start,
    input  logic        mdu_ready,
    input  logic        excp_req,
    input  logic [31:0] excp_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdu_cancel,
`ifdef STALL_SCHED_PERF_EN
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
`endif
    output logic        mdu_timeout_err
);

    localparam int STALL_BUS = 6;
    localparam int CNT_W = $clog2(MDU_TIMEOUT) + 1;
    localparam logic [STALL_BUS-1:0] STALL_MDU  = 6'b001111;
    localparam logic [STALL_BUS-1:0] STALL_LOAD = 6'b000111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              flush_nxt;
    logic [31:0]       new_pc_nxt;
    logic              cancel_nxt;
    logic              err_nxt;
    logic [STALL_BUS-1:0] stall_raw;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            flush           <= 1'b0;
            new_pc          <= 32'h0;
            mdu_cancel      <= 1'b0;
            mdu_timeout_err <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            flush           <= flush_nxt;
            new_pc          <= new_pc_nxt;
            mdu_cancel      <= cancel_nxt;
            mdu_timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        flush_nxt  = 1'b0;
        new_pc_nxt = new_pc;
        cancel_nxt = 1'b0;
        err_nxt    = mdu_timeout_err;
        stall_raw  = '0;
        case (state)
            IDLE: begin
                if (excp_req) begin
                    state_nxt  = FLUSH;
                    flush_nxt  = 1'b1;
                    new_pc_nxt = excp_pc;
                end else if (mdu_start) begin
                    stall_raw = STALL_MDU;
                    state_nxt = BUSY;
                    cnt_nxt   = '0;
                end else if (stallreq_for_load) begin
                    stall_raw = STALL_LOAD;
                end
            end
            BUSY: begin
                if (excp_req) begin
                    state_nxt  = FLUSH;
                    flush_nxt  = 1'b1;
                    new_pc_nxt = excp_pc;
                    cancel_nxt = 1'b1;
                end else if (mdu_ready) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    // Release the pipe now; cancel and error land with the return to IDLE.
                    state_nxt  = IDLE;
                    cancel_nxt = 1'b1;
                    err_nxt    = 1'b1;
                end else begin
                    stall_raw = STALL_MDU;
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
            FLUSH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign stall = rst ? stall_raw : '0;

`ifdef STALL_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall != '0 && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stall_sched.sv
// Randomized + directed bench for stall_sched against a rule-level reference model.
// Checks the STALL_SCHED_PERF_EN counters too when that macro is defined.
module tb_stall_sched;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        stallreq_for_load;
    logic        mdu_start;
    logic        mdu_ready;
    logic        excp_req;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mdu_cancel;
    logic        mdu_timeout_err;
`ifdef STALL_SCHED_PERF_EN
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    stall_sched #(.MDU_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .stallreq_for_load(stallreq_for_load),
        .mdu_start(mdu_start),
        .mdu_ready(mdu_ready),
        .excp_req(excp_req),
        .excp_pc(excp_pc),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .mdu_cancel(mdu_cancel),
`ifdef STALL_SCHED_PERF_EN
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
`endif
        .mdu_timeout_err(mdu_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: "busy" with an age count of waited cycles, a pending flush flag,
    // and the expected registered outputs.
    bit          m_busy;
    int          m_age;
    bit          m_in_flush;
    bit          m_flush;
    logic [31:0] m_pc;
    bit          m_cancel;
    bit          m_err;
    longint      m_stall_cnt;
    int          m_flush_cnt;

    function automatic logic [5:0] exp_stall();
        if (!rst || m_in_flush || excp_req) return 6'b0;
        if (m_busy) begin
            if (mdu_ready || m_age == TO - 1) return 6'b0;
            return 6'b001111;
        end
        if (mdu_start) return 6'b001111;
        if (stallreq_for_load) return 6'b000111;
        return 6'b0;
    endfunction

    task automatic model_edge(input logic [5:0] st);
        bit prev_flush;
        prev_flush = m_flush;
        if (!rst) begin
            m_busy = 0; m_age = 0; m_in_flush = 0; m_flush = 0;
            m_pc = 32'h0; m_cancel = 0; m_err = 0;
            m_stall_cnt = 0; m_flush_cnt = 0;
            return;
        end
        if (st != 6'b0 && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
        if (prev_flush && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
        m_cancel = 0;
        if (m_in_flush) begin
            m_in_flush = 0;
        end else if (excp_req) begin
            m_in_flush = 1;
            m_pc = excp_pc;
            m_cancel = m_busy;
            m_busy = 0;
        end else if (m_busy) begin
            if (mdu_ready) m_busy = 0;
            else if (m_age == TO - 1) begin
                m_busy = 0; m_cancel = 1; m_err = 1;
            end else m_age++;
        end else if (mdu_start) begin
            m_busy = 1;
            m_age = 0;
        end
        m_flush = m_in_flush;
    endtask

    task automatic step(input logic r, input logic ld, input logic st, input logic rdy,
                        input logic ex, input logic [31:0] pc);
        logic [5:0] es;
        @(negedge clk);
        check("flush", flush, m_flush);
        check("new_pc", new_pc, m_pc);
        check("mdu_cancel", mdu_cancel, m_cancel);
        check("timeout_err", mdu_timeout_err, m_err);
`ifdef STALL_SCHED_PERF_EN
        check("stall_cnt", stall_cnt, m_stall_cnt[31:0]);
        check("flush_cnt", flush_cnt, m_flush_cnt[15:0]);
`endif
        rst = r; stallreq_for_load = ld; mdu_start = st; mdu_ready = rdy;
        excp_req = ex; excp_pc = pc;
        #1;
        es = exp_stall();
        check("stall", stall, es);
        @(posedge clk);
        model_edge(es);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        rst = 0; stallreq_for_load = 0; mdu_start = 0; mdu_ready = 0;
        excp_req = 0; excp_pc = 32'h0;
        m_busy = 0; m_age = 0; m_in_flush = 0; m_flush = 0; m_pc = 0;
        m_cancel = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;

        // Reset with all requests high: stall must stay zero.
        step(0, 1, 1, 1, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 32'h0);
        idle(1);

        // Single-cycle load-use stall.
        step(1, 1, 0, 0, 0, 32'h0);
        idle(2);

        // mdu_start at 0, ready at 5.
        step(1, 0, 1, 0, 0, 32'h0);
        for (int i = 1; i < 5; i++) step(1, 1, 1, 0, 0, 32'h0);
        step(1, 0, 0, 1, 0, 32'h0);
        idle(1);

        // Exception on cycle 3 of an mdu op.
        step(1, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 1, 32'hBFC0_0380);
        step(1, 1, 1, 1, 1, 32'h1234_5678);
        idle(2);

        // mdu_start together with exception: BUSY never entered.
        step(1, 0, 1, 0, 1, 32'h8000_0180);
        idle(3);

        // Timeout with no ready, then reset clears the sticky error.
        step(1, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < TO + 4; i++) step(1, 1, 0, 0, 0, 32'h0);
        step(1, 0, 1, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        idle(1);

        // Reset mid-BUSY abandons the op silently.
        step(1, 0, 1, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 79) != 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 11) == 0),
                 $urandom);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
